// File: rtl/compute_distances.sv
// Distance writer: loads K centroids from the IO BRAM, then streams dist(point, centroid) into the DC BRAM.
// Optional macro DIST_MANHATTAN_EN selects |dx|+|dy| instead of saturated dx^2+dy^2.
module compute_distances #(
  parameter int ADDR_W       = 10,
  parameter int MAX_CLUSTERS = 8,
  parameter int CENT_BASE    = 0,
  parameter int POINT_BASE   = 16
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              start_i,
  output logic              ready_o,
  output logic              done_o,
  output logic              err_o,
  input  logic [31:0]       num_clusters_i,
  input  logic [31:0]       num_vals_i,
  output logic [ADDR_W-1:0] io_addr_o,
  input  logic [31:0]       io_din_i,
  output logic [ADDR_W-1:0] dc_addr_o,
  output logic [31:0]       dc_dout_o,
  output logic              dc_we_o
);

  localparam int CW = $clog2(MAX_CLUSTERS + 1);
  localparam int IW = (MAX_CLUSTERS > 1) ? $clog2(MAX_CLUSTERS) : 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD_CENT,
    ST_FETCH,
    ST_CAPTURE,
    ST_WRITE,
    ST_DONE
  } state_t;

  state_t r_state, w_next;

  logic [CW-1:0]     r_kk;
  logic [CW-1:0]     r_k;
  logic [CW-1:0]     r_c;
  logic [31:0]       r_n;
  logic [31:0]       r_p;
  logic [ADDR_W-1:0] r_wa;
  logic [31:0]       r_point;
  logic              r_err;
  logic [31:0]       r_cent [MAX_CLUSTERS];

  logic        w_bad;
  logic        w_last_c;
  logic        w_last_p;
  logic [31:0] w_cent;
  logic [15:0] w_dx;
  logic [15:0] w_dy;
  logic [31:0] w_dist;

  assign w_bad    = (num_clusters_i == 32'd0) || (num_clusters_i > 32'(MAX_CLUSTERS));
  assign w_last_c = (r_c == r_kk - CW'(1));
  assign w_last_p = (r_p == r_n - 32'd1);

  assign w_cent = r_cent[r_c[IW-1:0]];
  assign w_dx   = (r_point[15:0]  >= w_cent[15:0])  ? r_point[15:0]  - w_cent[15:0]
                                                    : w_cent[15:0]   - r_point[15:0];
  assign w_dy   = (r_point[31:16] >= w_cent[31:16]) ? r_point[31:16] - w_cent[31:16]
                                                    : w_cent[31:16]  - r_point[31:16];

`ifdef DIST_MANHATTAN_EN
  assign w_dist = {15'd0, {1'b0, w_dx} + {1'b0, w_dy}};
`else
  logic [31:0] w_sqx;
  logic [31:0] w_sqy;
  logic [32:0] w_sum;
  assign w_sqx  = 32'(w_dx) * 32'(w_dx);
  assign w_sqy  = 32'(w_dy) * 32'(w_dy);
  assign w_sum  = 33'(w_sqx) + 33'(w_sqy);
  assign w_dist = w_sum[32] ? '1 : w_sum[31:0];
`endif

  always_ff @(posedge clk_i) begin
    if (reset_i) r_state <= ST_IDLE;
    else         r_state <= w_next;
  end

  // Outputs are also gated by reset_i so an aborted pass stops writing in the very first reset cycle.
  always_comb begin
    w_next    = r_state;
    ready_o   = 1'b0;
    done_o    = 1'b0;
    dc_we_o   = 1'b0;
    dc_addr_o = '0;
    dc_dout_o = '0;
    io_addr_o = '0;
    case (r_state)
      ST_IDLE: begin
        ready_o = 1'b1;
        if (start_i) w_next = w_bad ? ST_DONE : ST_LOAD_CENT;
      end
      ST_LOAD_CENT: begin
        if (r_k < r_kk) io_addr_o = ADDR_W'(CENT_BASE) + ADDR_W'(r_k);
        else            w_next    = (r_n == 32'd0) ? ST_DONE : ST_FETCH;
      end
      ST_FETCH: begin
        io_addr_o = ADDR_W'(POINT_BASE) + ADDR_W'(r_p);
        w_next    = ST_CAPTURE;
      end
      ST_CAPTURE: w_next = ST_WRITE;
      ST_WRITE: begin
        dc_we_o   = 1'b1;
        dc_addr_o = r_wa;
        dc_dout_o = w_dist;
        if (w_last_c) w_next = w_last_p ? ST_DONE : ST_FETCH;
      end
      ST_DONE: begin
        done_o = 1'b1;
        w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
    if (reset_i) begin
      ready_o   = 1'b1;
      done_o    = 1'b0;
      dc_we_o   = 1'b0;
      dc_addr_o = '0;
      dc_dout_o = '0;
      io_addr_o = '0;
    end
  end

  assign err_o = r_err & ~reset_i;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_kk    <= '0;
      r_k     <= '0;
      r_c     <= '0;
      r_n     <= '0;
      r_p     <= '0;
      r_wa    <= '0;
      r_point <= '0;
      r_err   <= 1'b0;
      for (int unsigned i = 0; i < MAX_CLUSTERS; i++) r_cent[i] <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start_i) begin
            r_err <= w_bad;
            r_kk  <= w_bad ? '0 : CW'(num_clusters_i);
            r_n   <= num_vals_i;
            r_k   <= '0;
            r_c   <= '0;
            r_p   <= '0;
            r_wa  <= '0;
          end
        end
        ST_LOAD_CENT: begin
          r_k <= r_k + CW'(1);
          // Read data lags the address by one cycle, so cycle k captures word k-1.
          if (r_k != '0) r_cent[IW'(r_k - CW'(1))] <= io_din_i;
        end
        ST_CAPTURE: begin
          r_point <= io_din_i;
          r_c     <= '0;
        end
        ST_WRITE: begin
          r_c  <= r_c + CW'(1);
          r_wa <= r_wa + ADDR_W'(1);
          if (w_last_c) r_p <= r_p + 32'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_compute_distances.sv
// Scoreboard bench for compute_distances: IO BRAM model, expected writes queued, negedge monitor compares.
module tb_compute_distances;

  logic        clk_i;
  logic        reset_i;
  logic        start_i;
  logic        ready_o;
  logic        done_o;
  logic        err_o;
  logic [31:0] num_clusters_i;
  logic [31:0] num_vals_i;
  logic [9:0]  io_addr_o;
  logic [31:0] io_din_i;
  logic [9:0]  dc_addr_o;
  logic [31:0] dc_dout_o;
  logic        dc_we_o;

  logic [31:0] mem [1024];
  logic [63:0] exp_q [$];
  int n_cmp;
  int n_fail;

  compute_distances #(.ADDR_W(10), .MAX_CLUSTERS(8), .CENT_BASE(0), .POINT_BASE(16)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .start_i(start_i), .ready_o(ready_o),
    .done_o(done_o), .err_o(err_o), .num_clusters_i(num_clusters_i),
    .num_vals_i(num_vals_i), .io_addr_o(io_addr_o), .io_din_i(io_din_i),
    .dc_addr_o(dc_addr_o), .dc_dout_o(dc_dout_o), .dc_we_o(dc_we_o)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  always @(posedge clk_i) io_din_i <= mem[io_addr_o];

  always @(negedge clk_i) begin
    if (dc_we_o) begin
      logic [63:0] e;
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_write actual addr=%0d data=%h required none", dc_addr_o, dc_dout_o);
      end else begin
        e = exp_q.pop_front();
        if ({32'(dc_addr_o), dc_dout_o} !== e) begin
          n_fail++;
          $display("FAIL dc_write actual addr=%0d data=%h required addr=%0d data=%h",
                   dc_addr_o, dc_dout_o, e[63:32], e[31:0]);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] d);
    exp_q.push_back({a, d});
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 1024; i++) mem[i] = 32'd0;
  endtask

  task automatic setup_basic();
    clear_mem();
    mem[0]  = {16'd0, 16'd0};
    mem[1]  = {16'd4, 16'd3};
    mem[16] = {16'd4, 16'd3};
    mem[17] = {16'd8, 16'd6};
  endtask

  // Runs one pass; K/N are scrambled after the start edge to show they were sampled at start.
  task automatic run_pass(input logic [31:0] k, input logic [31:0] n, input int exp_lat,
                          input logic exp_err, input bit hold, input string nm, output int wr);
    int cyc;
    int rdy_bad;
    bit seen;
    wr = 0; rdy_bad = 0; seen = 0; cyc = 0;
    @(posedge clk_i); #1;
    num_clusters_i = k; num_vals_i = n; start_i = 1'b1;
    @(posedge clk_i); #1;
    if (!hold) start_i = 1'b0;
    num_clusters_i = k + 32'd5;
    num_vals_i     = n + 32'd3;
    for (int c = 1; c <= 2000; c++) begin
      @(negedge clk_i);
      if (ready_o) rdy_bad++;
      if (dc_we_o) wr++;
      if (done_o) begin
        seen = 1; cyc = c;
        break;
      end
    end
    if (hold) start_i = 1'b0;
    if (!seen) begin
      n_cmp++; n_fail++;
      $display("FAIL %s_timeout actual=no_done required=done", nm);
    end else begin
      chk({nm, "_latency"}, 32'(cyc), 32'(exp_lat));
      chk({nm, "_err"}, {31'd0, err_o}, {31'd0, exp_err});
      chk({nm, "_busy_ready"}, 32'(rdy_bad), 32'd0);
    end
    @(negedge clk_i);
    chk({nm, "_ready_after"}, {31'd0, ready_o}, 32'd1);
    chk({nm, "_pending"}, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  initial begin
    int wr;
    n_cmp = 0; n_fail = 0;
    reset_i = 1'b1; start_i = 1'b0; num_clusters_i = '0; num_vals_i = '0;
    clear_mem();
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    chk("rst_ready", {31'd0, ready_o}, 32'd1);
    chk("rst_done",  {31'd0, done_o},  32'd0);
    chk("rst_err",   {31'd0, err_o},   32'd0);
    chk("rst_we",    {31'd0, dc_we_o}, 32'd0);
    chk("rst_io",    32'(io_addr_o),   32'd0);
    chk("rst_dc",    32'(dc_addr_o),   32'd0);
    @(posedge clk_i); #1 reset_i = 1'b0;

    // Basic pass
    setup_basic();
`ifdef DIST_MANHATTAN_EN
    push(0, 7); push(1, 0); push(2, 14); push(3, 7);
`else
    push(0, 25); push(1, 0); push(2, 100); push(3, 25);
`endif
    run_pass(2, 2, 12, 1'b0, 1'b0, "basic", wr);
    chk("basic_writes", 32'(wr), 32'd4);

    // Saturation corner
    clear_mem();
    mem[16] = 32'hFFFF_FFFF;
`ifdef DIST_MANHATTAN_EN
    push(0, 32'h0001_FFFE);
`else
    push(0, 32'hFFFF_FFFF);
`endif
    run_pass(1, 1, 6, 1'b0, 1'b0, "sat", wr);

    // Configuration errors, then a valid N=0 pass clears err
    run_pass(0, 2, 1, 1'b1, 1'b0, "k0", wr);
    chk("k0_writes", 32'(wr), 32'd0);
    run_pass(9, 2, 1, 1'b1, 1'b0, "k9", wr);
    chk("k9_writes", 32'(wr), 32'd0);
    chk("err_sticky", {31'd0, err_o}, 32'd1);
    setup_basic();
    run_pass(2, 0, 4, 1'b0, 1'b0, "n0", wr);
    chk("n0_writes", 32'(wr), 32'd0);

    // start_i held through a K=3, N=4 pass
    clear_mem();
    mem[0] = {16'd0, 16'd0}; mem[1] = {16'd1, 16'd1}; mem[2] = {16'd0, 16'd2};
    mem[16] = {16'd0, 16'd1}; mem[17] = {16'd2, 16'd0};
    mem[18] = {16'd3, 16'd3}; mem[19] = {16'd1, 16'd5};
`ifdef DIST_MANHATTAN_EN
    push(0, 1);  push(1, 1);  push(2, 1);
    push(3, 2);  push(4, 2);  push(5, 4);
    push(6, 6);  push(7, 4);  push(8, 4);
    push(9, 6);  push(10, 4); push(11, 4);
`else
    push(0, 1);  push(1, 1);  push(2, 1);
    push(3, 4);  push(4, 2);  push(5, 8);
    push(6, 18); push(7, 8);  push(8, 10);
    push(9, 26); push(10, 16); push(11, 10);
`endif
    run_pass(3, 4, 25, 1'b0, 1'b1, "busy", wr);
    chk("busy_writes", 32'(wr), 32'd12);
    @(negedge clk_i);
    chk("busy_no_restart", {31'd0, ready_o}, 32'd1);

    // Reset during p=1 writes
    setup_basic();
`ifdef DIST_MANHATTAN_EN
    push(0, 7); push(1, 0); push(2, 14);
`else
    push(0, 25); push(1, 0); push(2, 100);
`endif
    @(posedge clk_i); #1;
    num_clusters_i = 2; num_vals_i = 2; start_i = 1'b1;
    @(posedge clk_i); #1 start_i = 1'b0;
    repeat (10) @(negedge clk_i);
    @(posedge clk_i); #1 reset_i = 1'b1;
    #1;
    chk("midrst_we",    {31'd0, dc_we_o}, 32'd0);
    chk("midrst_ready", {31'd0, ready_o}, 32'd1);
    chk("midrst_done",  {31'd0, done_o},  32'd0);
    @(negedge clk_i);
    chk("midrst_pending", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    repeat (2) @(posedge clk_i);
    #1 reset_i = 1'b0;
`ifdef DIST_MANHATTAN_EN
    push(0, 7); push(1, 0); push(2, 14); push(3, 7);
`else
    push(0, 25); push(1, 0); push(2, 100); push(3, 25);
`endif
    run_pass(2, 2, 12, 1'b0, 1'b0, "after_rst", wr);
    chk("after_rst_writes", 32'(wr), 32'd4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/compute_distances.md
COMPUTE_DISTANCES -- requirements
Module: compute_distances

Interface
REQ-001 SHALL have parameter ADDR_W, default 10: width of both BRAM address ports.
REQ-002 SHALL have parameter MAX_CLUSTERS, default 8: depth of the internal centroid register file.
REQ-003 SHALL have parameter CENT_BASE, default 0: IO BRAM word address of centroid 0.
REQ-004 SHALL have parameter POINT_BASE, default 16: IO BRAM word address of point 0.
REQ-005 SHALL have ports:
- clk_i  in  1  single clock; one clock, all logic on its rising edge.
- reset_i  in  1  reset, synchronous, active-high.
- start_i  in  1  begin a distance pass.
- ready_o  out  1  idle; start_i is accepted.
- done_o  out  1  one-cycle pulse at the end of a pass.
- err_o  out  1  configuration error, sticky until the next accepted start.
- num_clusters_i  in  32  K, the cluster count.
- num_vals_i  in  32  N, the point count.
- io_addr_o  out  ADDR_W  IO BRAM read address.
- io_din_i  in  32  IO BRAM read data; 1-cycle latency; word = {y[31:16], x[15:0]}, both unsigned.
- dc_addr_o  out  ADDR_W  DC BRAM write address.
- dc_dout_o  out  32  DC BRAM write data.
- dc_we_o  out  1  DC BRAM write enable.

Function
REQ-006 SHALL be the DC BRAM writer: for every point p < N and cluster c < K, write dist(p,c) at dc address p*K+c, truncated to ADDR_W.
REQ-007 SHALL accept start only when ready_o=1 and start_i=1 on the same edge; start_i while busy SHALL be ignored.
REQ-008 SHALL sample K and N at the accepted start and SHALL ignore later changes to them during the pass.
REQ-009 SHALL use states ST_IDLE, ST_LOAD_CENT, ST_FETCH, ST_CAPTURE, ST_WRITE, ST_DONE.
REQ-010 ST_LOAD_CENT SHALL last K+1 cycles:
- drive io_addr_o=CENT_BASE+k on cycle k, for k=0..K-1;
- capture io_din_i into centroid[k] on cycle k+1.
REQ-011 ST_FETCH SHALL last 1 cycle and drive io_addr_o=POINT_BASE+p.
REQ-012 ST_CAPTURE SHALL last 1 cycle and latch io_din_i as the current point.
REQ-013 ST_WRITE SHALL last K cycles:
- one write per cycle, c=0..K-1;
- dc_we_o=1, dc_addr_o=p*K+c, dc_dout_o=dist(p,c).
REQ-014 After the write for c=K-1, the block SHALL go to ST_FETCH for p+1, or to ST_DONE if p=N-1.
REQ-015 ST_DONE SHALL last 1 cycle with done_o=1, then go to ST_IDLE with ready_o=1.
REQ-016 Total pass latency SHALL be (K+1)+N*(K+2)+1 cycles from the start edge to the done_o cycle inclusive.
REQ-017 Default distance SHALL be dx*dx+dy*dy, where dx=|px-cx| and dy=|py-cy| (16-bit unsigned); a 33-bit sum SHALL saturate to 32'hFFFFFFFF.
REQ-018 If N=0, the block SHALL skip all writes, still perform ST_LOAD_CENT, then pulse done_o.
REQ-019 If K=0 or K>MAX_CLUSTERS at start, the block SHALL set err_o=1, perform no reads or writes, and pulse done_o on the cycle after start.
REQ-020 Outside ST_WRITE, dc_we_o, dc_addr_o and dc_dout_o SHALL be 0.
REQ-021 io_addr_o SHALL be 0 outside ST_LOAD_CENT and ST_FETCH.
REQ-022 The IO BRAM SHALL never be written by this block.

Reset
REQ-023 While reset_i=1, the block SHALL be in ST_IDLE with ready_o=1, done_o=0, err_o=0, dc_we_o=0 and all addresses, counters, centroids and the point at 0.
REQ-024 Reset asserted mid-pass SHALL abort the pass: no further writes, and dc_we_o=0 from the first reset cycle.

Configuration
REQ-025 When macro DIST_MANHATTAN_EN is defined, dist SHALL be dx+dy, zero-extended to 32 bits, with no saturation path.
REQ-026 When DIST_MANHATTAN_EN is undefined, dist SHALL be the saturated squared Euclidean distance of REQ-017.

Verification
REQ-027 Basic pass: K=2, N=2, centroids (0,0),(3,4), points (3,4),(6,8) -> writes addr0=25, addr1=0, addr2=100, addr3=25; done_o at cycle 3+2*4+1=12.
REQ-028 Manhattan pass: same stimulus with DIST_MANHATTAN_EN -> writes 7, 0, 14, 7.
REQ-029 Saturation: point (0xFFFF,0xFFFF), centroid (0,0), K=1, N=1 -> writes 32'hFFFFFFFF; with DIST_MANHATTAN_EN -> 32'h0001FFFE.
REQ-030 Config error: K=0, then K=MAX_CLUSTERS+1 -> err_o=1, no dc_we_o, done_o one cycle after start; next valid start clears err_o.
REQ-031 Busy start: start_i held high through a K=3, N=4 pass -> exactly 12 writes; a new pass begins only after ready_o returns.
REQ-032 Reset mid-pass: reset_i asserted during ST_WRITE of p=1 -> dc_we_o=0 immediately, ready_o=1, a following pass is correct.
